// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST: FSM state encoding, default LFSR
// seed and the feedback tap positions of the 32-bit pattern generator.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Feedback taps of the 32-bit Fibonacci LFSR (shift toward MSB, feedback into bit 0)
    localparam int unsigned LFSR_TAP_A = 31;
    localparam int unsigned LFSR_TAP_B = 21;
    localparam int unsigned LFSR_TAP_C = 1;
    localparam int unsigned LFSR_TAP_D = 0;

endpackage

// File: rtl/mem_bist_lfsr.sv
// 32-bit pattern generator for the BIST.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, forces value to SEED
//   load_i  - reload SEED on the next edge (wins over step_i)
//   step_i  - advance one LFSR step on the next edge
//   value_o - current 32-bit LFSR state
module mem_bist_lfsr
    import mem_bist_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B] ^ lfsr_q[LFSR_TAP_C] ^ lfsr_q[LFSR_TAP_D];
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[30:0], fb};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/mem_bist.sv
// Memory BIST controller: fills an asynchronous-read memory with an LFSR
// pattern, then reads every location back and compares against the same
// pattern regenerated from the seed.
// Ports:
//   Clk, Rst   - clock, asynchronous active-high reset
//   Start      - run request, honoured only in IDLE or DONE
//   WE/Addr/WrData - memory write port (Addr is also the read address)
//   RdData     - combinational read data from the memory
//   Busy       - high while writing or reading
//   Done/Pass  - run finished / finished with no mismatches
//   ErrCount   - number of mismatching addresses in the current run
//   FailAddr   - first mismatching address of the current run
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] SEED       = DEFAULT_SEED
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic [ADDR_WIDTH:0]   ErrCount,
    output logic [ADDR_WIDTH-1:0] FailAddr
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] fail_q;
    logic [ADDR_WIDTH:0]   err_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;

    logic [31:0] lfsr_val;
    logic        start_ok;
    logic        last_addr;
    logic        mismatch;
    logic        lfsr_load;
    logic        lfsr_step;

    assign start_ok  = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_addr = &addr_q;
    assign mismatch  = (state_q == ST_READ) && (RdData != lfsr_val[DATA_WIDTH-1:0]);
    // Reload at the end of the write sweep so the read sweep regenerates the
    // exact same pattern sequence.
    assign lfsr_load = start_ok || ((state_q == ST_WRITE) && last_addr);
    assign lfsr_step = (state_q == ST_WRITE) || (state_q == ST_READ);

    mem_bist_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .value_o (lfsr_val)
    );

    // The address counter wraps to 0 after each sweep, so it is already 0 in
    // IDLE and DONE and can drive Addr directly.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state_q <= ST_WRITE;
                        addr_q  <= '0;
                        fail_q  <= '0;
                        err_q   <= '0;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + 1'b1;
                    if (last_addr) begin
                        state_q <= ST_READ;
                        we_q    <= 1'b0;
                    end
                end
                ST_READ: begin
                    addr_q <= addr_q + 1'b1;
                    // At most DEPTH mismatches per run, which fits in ADDR_WIDTH+1 bits.
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (err_q == '0) begin
                            fail_q <= addr_q;
                        end
                    end
                    if (last_addr) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign WE       = we_q;
    assign Addr     = addr_q;
    assign WrData   = we_q ? lfsr_val[DATA_WIDTH-1:0] : '0;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Pass     = pass_q;
    assign ErrCount = err_q;
    assign FailAddr = fail_q;

endmodule

// File: tb/tb_mem_bist.sv
module tb_mem_bist;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int D  = 1 << AW;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Start = 1'b0;
    logic          WE, Busy, Done, Pass;
    logic [AW-1:0] Addr, FailAddr;
    logic [DW-1:0] WrData, RdData;
    logic [AW:0]   ErrCount;

    logic          Start2 = 1'b0;
    logic          WE2, Busy2, Done2, Pass2;
    logic [1:0]    Addr2, FailAddr2;
    logic [7:0]    WrData2, RdData2;
    logic [2:0]    ErrCount2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEED(32'h0000_0001)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .WE(WE), .Addr(Addr), .WrData(WrData),
        .RdData(RdData), .Busy(Busy), .Done(Done), .Pass(Pass),
        .ErrCount(ErrCount), .FailAddr(FailAddr));

    mem_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SEED(32'h0000_0001)) dut2 (
        .Clk(Clk), .Rst(Rst), .Start(Start2), .WE(WE2), .Addr(Addr2), .WrData(WrData2),
        .RdData(RdData2), .Busy(Busy2), .Done(Done2), .Pass(Pass2),
        .ErrCount(ErrCount2), .FailAddr(FailAddr2));

    // Async-read memories; flip[] injects read-side bit errors per address.
    logic [DW-1:0] mem  [D];
    logic [DW-1:0] flip [D];
    logic [7:0]    mem2 [4];
    always @(posedge Clk) if (WE) mem[Addr] <= WrData;
    assign RdData = mem[Addr] ^ flip[Addr];
    always @(posedge Clk) if (WE2) mem2[Addr2] <= WrData2;
    assign RdData2 = mem2[Addr2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Expected pattern: the k-th write of a run carries seq[k].
    logic [31:0] seq [D];
    initial begin
        seq[0] = 32'h0000_0001;
        for (int i = 1; i < D; i++) seq[i] = lfsr_next(seq[i-1]);
    end

    // Reference model: a run is just "cycles elapsed since Start was accepted".
    typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
    mmode_t        m_mode = M_IDLE;
    int            m_k = 0;
    logic [DW-1:0] m_flip [D];

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_mode = M_IDLE;
            m_k    = 0;
        end else if (m_mode != M_RUN) begin
            if (Start) begin
                m_mode = M_RUN;
                m_k    = 0;
                for (int i = 0; i < D; i++) m_flip[i] = flip[i];
            end
        end else begin
            m_k++;
            if (m_k == 2 * D) m_mode = M_DONE;
        end
    end

    function automatic logic [127:0] pack(input logic we, input logic busy, input logic done,
                                          input logic pass, input logic [AW:0] err,
                                          input logic [AW-1:0] fa, input logic [AW-1:0] ad,
                                          input logic [DW-1:0] wd);
        return 128'({we, busy, done, pass, err, fa, ad, wd});
    endfunction

    always @(negedge Clk) begin
        logic          e_we, e_busy, e_done, e_pass, rdph;
        logic [AW:0]   e_err;
        logic [AW-1:0] e_fa, e_ad;
        logic [DW-1:0] e_wd;
        int            n, cnt, first;
        if (chk_en) begin
            e_we = 0; e_busy = 0; e_done = 0; e_pass = 0; rdph = 0;
            e_err = '0; e_fa = '0; e_ad = '0; e_wd = '0;
            if (!Rst && m_mode == M_RUN && m_k < D) begin
                e_we = 1; e_busy = 1; e_ad = AW'(m_k); e_wd = seq[m_k][DW-1:0];
            end else if (!Rst && m_mode != M_IDLE) begin
                n = (m_mode == M_RUN) ? m_k - D : D;
                cnt = 0; first = -1;
                for (int i = 0; i < n; i++)
                    if (m_flip[i] != '0) begin
                        cnt++;
                        if (first < 0) first = i;
                    end
                e_err = (AW+1)'(cnt);
                e_fa  = (first < 0) ? '0 : AW'(first);
                if (m_mode == M_RUN) begin
                    e_busy = 1; e_ad = AW'(n); rdph = 1;
                end else begin
                    e_done = 1; e_pass = (cnt == 0);
                end
            end
            check("cycle", pack(WE, Busy, Done, Pass, ErrCount, FailAddr, Addr,
                                rdph ? {DW{1'b0}} : WrData),
                  pack(e_we, e_busy, e_done, e_pass, e_err, e_fa, e_ad, e_wd));
        end
    end

    int wr2_cnt = 0, rd2_cnt = 0;
    logic [1:0] wr2_last = '0;
    always @(negedge Clk) begin
        if (WE2) begin wr2_cnt++; wr2_last = Addr2; end
        if (Busy2 && !WE2) rd2_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (!Done && lat < 3 * D) begin tick(); lat++; end
        check(name, 128'(Done), 128'(1));
    endtask

    task automatic run(input string name, output int lat);
        Start = 1'b1; tick(); Start = 1'b0;
        wait_done(name, lat);
    endtask

    task automatic clear_flips();
        for (int i = 0; i < D; i++) flip[i] = '0;
    endtask

    initial begin
        int lat, ecnt, efirst, nf, a;
        clear_flips();
        #1 Rst = 1'b1;
        chk_en = 1'b1;
        tick(2);
        check("reset_state", pack(WE, Busy, Done, Pass, ErrCount, FailAddr, Addr, WrData), '0);
        Rst = 1'b0;
        tick();

        // healthy run
        run("done_healthy", lat);
        check("latency", 128'(lat), 128'(2049));
        check("pass_healthy", 128'(Pass), 128'(1));
        check("err_healthy", 128'(ErrCount), 128'(0));
        check("wr0", 128'(mem[0]), 128'(32'h1));
        check("wr1", 128'(mem[1]), 128'(32'h3));
        check("wr2", 128'(mem[2]), 128'(32'h6));
        tick(3);

        // single fault at address 5
        flip[5] = 32'h1;
        run("done_f5", lat);
        check("err_f5", 128'(ErrCount), 128'(1));
        check("fail_f5", 128'(FailAddr), 128'(5));
        check("pass_f5", 128'(Pass), 128'(0));
        clear_flips();

        // faults at 7 and 900
        flip[7] = 32'h1; flip[900] = 32'h1;
        run("done_f7", lat);
        check("err_f7", 128'(ErrCount), 128'(2));
        check("fail_f7", 128'(FailAddr), 128'(7));
        clear_flips();
        tick(2);

        // Start held: restart from DONE clears ErrCount, no restart mid-run
        Start = 1'b1;
        tick();
        check("held_busy", 128'(Busy), 128'(1));
        check("held_err_clr", 128'(ErrCount), 128'(0));
        wait_done("held_done", lat);
        check("held_lat", 128'(lat), 128'(2049));
        check("held_pass", 128'(Pass), 128'(1));
        tick();
        check("held_restart", 128'({Busy, Done}), 128'(2'b10));
        Start = 1'b0;
        wait_done("held_done2", lat);

        // reset mid-write
        Start = 1'b1; tick(); Start = 1'b0;
        tick(300);
        check("pre_rst_we", 128'(WE), 128'(1));
        #2 Rst = 1'b1;
        #1 check("rst_we", 128'({WE, Busy}), 128'(0));
        @(posedge Clk); #1 Rst = 1'b0;
        tick();
        run("done_after_rst", lat);
        check("lat_after_rst", 128'(lat), 128'(2049));
        check("pass_after_rst", 128'(Pass), 128'(1));

        // random fault sets
        for (int r = 0; r < 3; r++) begin
            clear_flips();
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) begin
                a = $urandom_range(0, D - 1);
                flip[a] = 32'h1 << $urandom_range(0, 31);
            end
            ecnt = 0; efirst = 0;
            for (int i = D - 1; i >= 0; i--)
                if (flip[i] != '0) begin ecnt++; efirst = i; end
            tick($urandom_range(0, 5));
            run("done_rand", lat);
            check("err_rand", 128'(ErrCount), 128'(ecnt));
            check("fail_rand", 128'(FailAddr), 128'(efirst));
            check("pass_rand", 128'(Pass), 128'(ecnt == 0));
        end
        clear_flips();

        // small configuration: 4-deep, 8-bit
        wr2_cnt = 0; rd2_cnt = 0;
        Start2 = 1'b1; tick(); Start2 = 1'b0;
        lat = 1;
        while (!Done2 && lat < 100) begin tick(); lat++; end
        check("s_done", 128'(Done2), 128'(1));
        check("s_latency", 128'(lat), 128'(9));
        check("s_writes", 128'(wr2_cnt), 128'(4));
        check("s_reads", 128'(rd2_cnt), 128'(4));
        check("s_last_addr", 128'(wr2_last), 128'(3));
        check("s_mem0", 128'(mem2[0]), 128'(8'h01));
        check("s_mem2", 128'(mem2[2]), 128'(8'h06));
        check("s_mem3", 128'(mem2[3]), 128'(seq[3][7:0]));
        check("s_pass", 128'({Pass2, ErrCount2}), 128'(4'b1000));

        tick(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
